// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the sequential NxN matrix multiplier.
// Element indexing is row-major; result width grows with log2(N) so sums never wrap.
package matmul_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int elem_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

  function automatic int calc_cw(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  // Counter width; a 1x1 matrix still needs a one-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Combinational multiply-accumulate: acc_out = acc_in + a*b, product extended to CW
// either by zero-extension or sign-extension depending on SIGNED.
module matmul_mac #(
  parameter int DW     = 8,
  parameter int CW     = 17,
  parameter int SIGNED = 0
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [CW-1:0] acc_in,
  output logic [CW-1:0] acc_out
);

  logic [CW-1:0] prod_ext_s;

  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [2*DW-1:0] prod_s;
      assign prod_s     = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
      assign prod_ext_s = CW'(prod_s);
    end else begin : g_unsigned
      logic [2*DW-1:0] prod_s;
      assign prod_s     = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      assign prod_ext_s = CW'(prod_s);
    end
  endgenerate

  assign acc_out = acc_in + prod_ext_s;

endmodule

// File: rtl/matrix_mul_seq.sv
// Sequential NxN matrix multiplier C = A x B using one MAC per cycle (N^3 cycles per job).
// Operands are latched on start; c_flat updates atomically on completion with a one-cycle done pulse.
module matrix_mul_seq
  import matmul_pkg::*;
#(
  parameter  int N      = 2,
  parameter  int DW     = 8,
  parameter  int SIGNED = 0,
  localparam int CW     = calc_cw(DW, N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N*N*DW-1:0]   a_flat,
  input  logic [N*N*DW-1:0]   b_flat,
  output logic                busy,
  output logic                done,
  output logic [N*N*CW-1:0]   c_flat
);

  localparam int              CNTW = cnt_w(N);
  localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);
  localparam logic [CNTW-1:0] ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] ZERO = CNTW'(0);

  state_t              state_r, state_next_s;
  logic [N*N*DW-1:0]   a_reg_r, b_reg_r;
  logic [CNTW-1:0]     i_r, j_r, k_r;
  logic [CW-1:0]       acc_r;
  logic [N*N*CW-1:0]   res_r, res_next_s, c_flat_r;
  logic                busy_r, done_r;
  logic [DW-1:0]       a_sel_s, b_sel_s;
  logic [CW-1:0]       mac_out_s;
  logic                last_mac_s;

  assign busy       = busy_r;
  assign done       = done_r;
  assign c_flat     = c_flat_r;
  assign last_mac_s = (i_r == LAST) && (j_r == LAST) && (k_r == LAST);

  // Operand fetch for the current (i,k) x (k,j) term and the working result with the new element merged in.
  always_comb begin
    a_sel_s    = a_reg_r[elem_idx(int'(i_r), int'(k_r), N) * DW +: DW];
    b_sel_s    = b_reg_r[elem_idx(int'(k_r), int'(j_r), N) * DW +: DW];
    res_next_s = res_r;
    res_next_s[elem_idx(int'(i_r), int'(j_r), N) * CW +: CW] = mac_out_s;
  end

  matmul_mac #(
    .DW     (DW),
    .CW     (CW),
    .SIGNED (SIGNED)
  ) u_mac (
    .a       (a_sel_s),
    .b       (b_sel_s),
    .acc_in  (acc_r),
    .acc_out (mac_out_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_mac_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath: operand capture, i/j/k walk, accumulation and the result bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg_r  <= '0;
      b_reg_r  <= '0;
      i_r      <= ZERO;
      j_r      <= ZERO;
      k_r      <= ZERO;
      acc_r    <= '0;
      res_r    <= '0;
      c_flat_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_reg_r <= a_flat;
            b_reg_r <= b_flat;
            i_r     <= ZERO;
            j_r     <= ZERO;
            k_r     <= ZERO;
            acc_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        RUN: begin
          if (k_r != LAST) begin
            acc_r <= mac_out_s;
            k_r   <= k_r + ONE;
          end else begin
            res_r <= res_next_s;
            acc_r <= '0;
            k_r   <= ZERO;
            if (j_r != LAST) begin
              j_r <= j_r + ONE;
            end else begin
              j_r <= ZERO;
              i_r <= (i_r == LAST) ? ZERO : i_r + ONE;
            end
            // Publish the whole matrix at once, including the element finished on this edge.
            if (last_mac_s) begin
              c_flat_r <= res_next_s;
              done_r   <= 1'b1;
              busy_r   <= 1'b0;
            end
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Self-checking bench for matrix_mul_seq: unsigned 2x2, signed 2x2 and unsigned 3x3 (DW=4) instances,
// with a scoreboard queue per matrix size holding expected results.
module tb_matrix_mul_seq;

  logic        clk;
  logic        rst;
  logic        start_u, start_s, start_3;
  logic [31:0] a2, b2;
  logic [35:0] a3, b3;
  logic        busy_u, done_u, busy_s, done_s, busy_3, done_3;
  logic [67:0] c_u, c_s;
  logic [89:0] c_3;
  logic        sel2;
  logic        busy2, done2;
  logic [67:0] c2;

  int checks = 0;
  int errors = 0;

  logic [67:0] q2[$];
  logic [89:0] q3[$];

  matrix_mul_seq #(.N(2), .DW(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start(start_u), .a_flat(a2), .b_flat(b2),
    .busy(busy_u), .done(done_u), .c_flat(c_u)
  );

  matrix_mul_seq #(.N(2), .DW(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .a_flat(a2), .b_flat(b2),
    .busy(busy_s), .done(done_s), .c_flat(c_s)
  );

  matrix_mul_seq #(.N(3), .DW(4), .SIGNED(0)) dut_3 (
    .clk(clk), .rst(rst), .start(start_3), .a_flat(a3), .b_flat(b3),
    .busy(busy_3), .done(done_3), .c_flat(c_3)
  );

  assign busy2 = sel2 ? busy_s : busy_u;
  assign done2 = sel2 ? done_s : done_u;
  assign c2    = sel2 ? c_s : c_u;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Straightforward triple-loop reference, elements packed row-major.
  function automatic logic [127:0] ref_mm(input logic [127:0] a, input logic [127:0] b,
                                          input int n, input int dw, input int cw, input bit sgn);
    logic [127:0] res, ta, tb, te;
    longint sum, ea, eb;
    res = '0;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        sum = 0;
        for (int k = 0; k < n; k++) begin
          ta = a >> ((r * n + k) * dw);
          tb = b >> ((k * n + c) * dw);
          ea = longint'(ta[31:0] & ((32'd1 << dw) - 32'd1));
          eb = longint'(tb[31:0] & ((32'd1 << dw) - 32'd1));
          if (sgn && ea[dw-1]) ea = ea - (longint'(1) << dw);
          if (sgn && eb[dw-1]) eb = eb - (longint'(1) << dw);
          sum = sum + ea * eb;
        end
        te  = 128'(sum) & ((128'd1 << cw) - 128'd1);
        res = res | (te << ((r * n + c) * cw));
      end
    end
    return res;
  endfunction

  task automatic set_start2(input bit sgn, input logic v);
    if (sgn) start_s = v;
    else     start_u = v;
  endtask

  // Launch a 2x2 job and observe until done; optionally re-pulse start with other operands at poke_cyc.
  task automatic run2(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                      input int poke_cyc, input logic [31:0] pa, input logic [31:0] pb,
                      output int lat, output int bcnt, output bit seen, output logic [67:0] c);
    sel2 = sgn;
    a2 = a;
    b2 = b;
    set_start2(sgn, 1'b1);
    lat = 0; bcnt = 0; seen = 1'b0; c = '0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      if (busy2) bcnt++;
      if (done2) begin
        seen = 1'b1;
        lat  = cyc - 1;
        c    = c2;
      end
      if (poke_cyc != 0 && cyc == poke_cyc) begin
        a2 = pa; b2 = pb;
        set_start2(sgn, 1'b1);
      end else begin
        set_start2(sgn, 1'b0);
        if (cyc == 1) begin
          a2 = $urandom; b2 = $urandom;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_u = 1'b0; start_s = 1'b0; start_3 = 1'b0;
    a2 = '0; b2 = '0; a3 = '0; b3 = '0; sel2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (busy_u !== 1'b0 || busy_s !== 1'b0 || busy_3 !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got u=%b s=%b 3=%b, want 0", busy_u, busy_s, busy_3); end
    checks++; if (done_u !== 1'b0 || done_s !== 1'b0 || done_3 !== 1'b0) begin
      errors++; $display("FAIL reset_done: got u=%b s=%b 3=%b, want 0", done_u, done_s, done_3); end
    checks++; if (c_u !== 68'd0 || c_s !== 68'd0 || c_3 !== 90'd0) begin
      errors++; $display("FAIL reset_c: got u=%h s=%h 3=%h, want 0", c_u, c_s, c_3); end
  endtask

  task automatic check_job2(input string name, input int lat, input int bcnt, input bit seen,
                            input logic [67:0] c);
    logic [67:0] exp;
    exp = (q2.size() > 0) ? q2.pop_front() : 68'hx;
    checks++; if (!seen) begin errors++; $display("FAIL %s_timeout: no done within 40 cycles", name); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL %s_latency: got %0d, want 8", name, lat); end
    checks++; if (bcnt !== 8) begin errors++; $display("FAIL %s_busy_cycles: got %0d, want 8", name, bcnt); end
    checks++; if (c !== exp) begin errors++; $display("FAIL %s_result: got %h, want %h", name, c, exp); end
  endtask

  task automatic test_basic;
    int lat, bcnt; bit seen; logic [67:0] c;
    q2.push_back({17'd50, 17'd43, 17'd22, 17'd19});
    run2(1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 0, 32'd0, 32'd0, lat, bcnt, seen, c);
    check_job2("basic", lat, bcnt, seen, c);
    @(negedge clk);
    checks++; if (done_u !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b, want 0", done_u); end
    checks++; if (c_u !== {17'd50, 17'd43, 17'd22, 17'd19}) begin
      errors++; $display("FAIL basic_hold: got %h, want %h", c_u, {17'd50, 17'd43, 17'd22, 17'd19}); end
  endtask

  task automatic test_max;
    int lat, bcnt; bit seen; logic [67:0] c;
    q2.push_back({4{17'd130050}});
    run2(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd0, 32'd0, lat, bcnt, seen, c);
    check_job2("max", lat, bcnt, seen, c);
  endtask

  task automatic test_signed;
    int lat, bcnt; bit seen; logic [67:0] c;
    q2.push_back({17'h1FFCE, 17'd43, 17'd22, 17'h1FFED});
    run2(1'b1, {8'hFC, 8'd3, 8'd2, 8'hFF}, {8'd8, 8'hF9, 8'hFA, 8'd5}, 0, 32'd0, 32'd0, lat, bcnt, seen, c);
    check_job2("signed", lat, bcnt, seen, c);
  endtask

  task automatic test_ignore_start;
    int lat, bcnt, extra; bit seen; logic [67:0] c, tmp;
    logic [31:0] a, b;
    a = 32'h0A_03_07_02; b = 32'h05_0B_01_09;
    tmp = ref_mm(128'(a), 128'(b), 2, 8, 17, 1'b0);
    q2.push_back(tmp[67:0]);
    run2(1'b0, a, b, 3, 32'hFFFF_FFFF, 32'h1111_1111, lat, bcnt, seen, c);
    check_job2("ignore", lat, bcnt, seen, c);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_u) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_single_done: got %0d extra, want 0", extra); end
    checks++; if (busy_u !== 1'b0) begin errors++; $display("FAIL ignore_idle: busy got %b, want 0", busy_u); end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, extra; bit seen; logic [67:0] c, tmp;
    logic [31:0] a, b;
    sel2 = 1'b0;
    a2 = $urandom; b2 = $urandom;
    start_u = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      start_u = 1'b0;
      if (cyc == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy_u !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, want 0", busy_u); end
    checks++; if (done_u !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b, want 0", done_u); end
    checks++; if (c_u !== 68'd0) begin errors++; $display("FAIL rstmid_c: got %h, want 0", c_u); end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_u) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d, want 0", extra); end
    a = 32'h02_00_00_02; b = 32'h0D_2C_63_F1;
    tmp = ref_mm(128'(a), 128'(b), 2, 8, 17, 1'b0);
    q2.push_back(tmp[67:0]);
    run2(1'b0, a, b, 0, 32'd0, 32'd0, lat, bcnt, seen, c);
    check_job2("rstmid_after", lat, bcnt, seen, c);
  endtask

  // start held high: each job is accepted on the edge after the previous done, so a new done every 28 cycles.
  task automatic test_back_to_back;
    logic [63:0] r64;
    logic [127:0] tmp;
    logic [89:0] exp;
    int lat; bit seen;
    r64 = {$urandom, $urandom}; a3 = r64[35:0];
    r64 = {$urandom, $urandom}; b3 = r64[35:0];
    tmp = ref_mm(128'(a3), 128'(b3), 3, 4, 10, 1'b0);
    q3.push_back(tmp[89:0]);
    start_3 = 1'b1;
    for (int job = 0; job < 4; job++) begin
      seen = 1'b0; lat = 0;
      for (int t = 1; t <= 60 && !seen; t++) begin
        @(negedge clk);
        if (done_3) begin seen = 1'b1; lat = t; end
      end
      exp = (q3.size() > 0) ? q3.pop_front() : 90'hx;
      checks++; if (!seen) begin errors++; $display("FAIL b2b_timeout job %0d: no done within 60 cycles", job); end
      checks++; if (lat !== 28) begin errors++; $display("FAIL b2b_period job %0d: got %0d, want 28", job, lat); end
      checks++; if (c_3 !== exp) begin errors++; $display("FAIL b2b_result job %0d: got %h, want %h", job, c_3, exp); end
      if (job < 3) begin
        r64 = {$urandom, $urandom}; a3 = r64[35:0];
        r64 = {$urandom, $urandom}; b3 = r64[35:0];
        tmp = ref_mm(128'(a3), 128'(b3), 3, 4, 10, 1'b0);
        q3.push_back(tmp[89:0]);
      end else begin
        start_3 = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (busy_3 !== 1'b0 || done_3 !== 1'b0) begin
      errors++; $display("FAIL b2b_stop: busy=%b done=%b, want 0 0", busy_3, done_3); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_signed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
